signed_vedic_mult: RTL and testbench
====================================

Name: signed_vedic_mult

Overview:
- Registered signed two's-complement multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Built on a recursive unsigned Vedic (Urdhva-Tiryagbhyam) core with a 2x2-bit base cell, cascaded up to WIDTH.
- Sign handling is sign-magnitude around the unsigned core.
- Used as the arithmetic leaf in datapaths that need a fixed-latency signed product.

Parameters:
- WIDTH, 32, operand width in bits; power of two, >= 2 (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  signed multiplicand, two's complement.
- b  input  WIDTH  signed multiplier, two's complement.
- out  output  2*WIDTH  signed product a*b, two's complement, registered.

Behaviour:
- Reset: rst_n low asynchronously clears out to 0. Deassertion is synchronised externally.
- No handshake. A new operand pair is accepted every cycle.
- Latency is 1 cycle: out at edge N+1 = a*b sampled at edge N. Throughput is 1 per cycle.
- Sign stage:
  - sa = a[WIDTH-1], sb = b[WIDTH-1].
  - |a| = sa ? (~a + 1) : a, computed as a WIDTH-bit unsigned value. Same for |b|.
  - For the most negative input -2^(WIDTH-1), the magnitude 2^(WIDTH-1) is represented correctly as unsigned.
- Unsigned core (combinational), recursive on width n:
  - n = 2: 2x2 base cell built from AND gates and half adders; 4-bit result.
  - n > 2: split each operand into hi and lo halves of n/2 bits.
  - Form four n/2 products: ll, lh, hl, hh.
  - Sum = ll + ((lh + hl) << n/2) + (hh << n), with a 2n-bit result.
  - Adders are plain behavioural `+` at each level.
- Result stage: p = sa^sb ? (~mag + 1) : mag, as a 2*WIDTH-bit value, registered into out.
- Range: the product always fits in 2*WIDTH signed bits; no overflow or saturation.
  - (-2^(W-1)) * (-2^(W-1)) = 2^(2W-2) is positive and representable.
- Zero operand gives out = 0 regardless of the sign bits. Negating zero yields zero, so no special case is needed.
- Reset asserted mid-stream: out is cleared immediately. The first valid result appears 1 cycle after the first edge with rst_n high.
- X on a or b propagates to out only; there is no other state.

Optional Feature:
- Macro: SIGNED_VEDIC_MULT_INREG_EN.
- Defined:
  - a and b are registered on input, in addition to the output register.
  - Both registers are cleared by rst_n.
  - Latency becomes 2 cycles; throughput is unchanged.
- Undefined: latency is 1 cycle as above. Port list is identical in both builds.

Decomposition:
- Package signed_vedic_pkg holds:
  - localparam VEDIC_BASE_W = 2;
  - function is_pow2(int) for parameter checking;
  - typedef for the 2-bit base operand.
- One sub-module, vedic_umult #(N):
  - Unsigned N x N -> 2N, purely combinational.
  - Self-recursive via generate; N = 2 selects the base cell.
- signed_vedic_mult instantiates a single vedic_umult #(WIDTH) and contains the sign stage, the result stage and the registers.

Test Plan (WIDTH = 32, check 1 cycle after apply, 2 cycles with SIGNED_VEDIC_MULT_INREG_EN):
- Reset: rst_n = 0 with arbitrary a and b -> out = 64'h0 immediately, without waiting for a clock edge.
- Sign quadrants:
  - a = 0x00000002, b = 0x00000003 -> out = 64'h0000000000000006.
  - a = 0xFFFFFFFE, b = 0x00000003 -> out = 64'hFFFFFFFFFFFFFFFA.
  - a = 0x00000002, b = 0xFFFFFFFD -> out = 64'hFFFFFFFFFFFFFFFA.
  - a = 0xFFFFFFFE, b = 0xFFFFFFFD -> out = 64'h0000000000000006.
- Extremes:
  - a = b = 0x80000000 -> out = 64'h4000000000000000.
  - a = 0x7FFFFFFF, b = 0x80000000 -> out = 64'hC000000080000000.
  - a = 0, b = 0xFFFFFFFF -> out = 0.
- Back-to-back: change a and b every cycle for 1000 cycles of random values -> each out equals $signed(a)*$signed(b) from 1 cycle earlier.
- Mid-stream reset: drop rst_n between two valid operand pairs -> out = 0 while rst_n is low; the next result is correct 1 cycle after release.
- Parameter sweep: WIDTH = 2, 4, 8, exhaustive for 2 and 4 -> all products match the signed reference.

Source files
------------

// File: rtl/signed_vedic_pkg.sv
// rtl/signed_vedic_pkg.sv - shared constants, types and parameter check for the signed Vedic multiplier
package signed_vedic_pkg;

  localparam int VEDIC_BASE_W = 2;

  typedef logic [VEDIC_BASE_W-1:0] base_op_t;

  function automatic bit is_pow2(int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/vedic_umult.sv
// rtl/vedic_umult.sv - unsigned N x N -> 2N Urdhva-Tiryagbhyam multiplier, recursive down to a 2x2 cell
module vedic_umult
  import signed_vedic_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  generate
    if (N == VEDIC_BASE_W) begin : g_base
      base_op_t x, y;
      logic     c_lh, c_hl, k1, c_hh;

      assign x    = a;
      assign y    = b;
      assign c_lh = x[1] & y[0];
      assign c_hl = x[0] & y[1];
      assign c_hh = x[1] & y[1];
      // two half adders: cross terms, then carry into the high partial product
      assign k1   = c_lh & c_hl;
      assign p[0] = x[0] & y[0];
      assign p[1] = c_lh ^ c_hl;
      assign p[2] = c_hh ^ k1;
      assign p[3] = c_hh & k1;
    end else begin : g_rec
      localparam int H = N / 2;
      logic [N-1:0] ll, lh, hl, hh;
      logic [N:0]   mid;

      vedic_umult #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
      vedic_umult #(.N(H)) u_lh (.a(a[N-1:H]), .b(b[H-1:0]), .p(lh));
      vedic_umult #(.N(H)) u_hl (.a(a[H-1:0]), .b(b[N-1:H]), .p(hl));
      vedic_umult #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));

      assign mid = {1'b0, lh} + {1'b0, hl};
      assign p   = {{N{1'b0}}, ll}
                 + ({{(N-1){1'b0}}, mid} << H)
                 + {hh, {N{1'b0}}};
    end
  endgenerate

endmodule

// File: rtl/signed_vedic_mult.sv
// rtl/signed_vedic_mult.sv - registered signed WIDTH x WIDTH multiplier around an unsigned Vedic core
// SIGNED_VEDIC_MULT_INREG_EN adds an input register stage (latency 2 instead of 1).
module signed_vedic_mult
  import signed_vedic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   out
);

  generate
    if (!is_pow2(WIDTH) || WIDTH < VEDIC_BASE_W) begin : g_bad_width
      $error("signed_vedic_mult: WIDTH must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0]   a_op, b_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] mag, prod;
  logic               sa, sb;

`ifdef SIGNED_VEDIC_MULT_INREG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_op <= '0;
      b_op <= '0;
    end else begin
      a_op <= a;
      b_op <= b;
    end
  end
`else
  assign a_op = a;
  assign b_op = b;
`endif

  assign sa = a_op[WIDTH-1];
  assign sb = b_op[WIDTH-1];
  // -2^(W-1) negates to itself, which read as unsigned is exactly its magnitude
  assign mag_a = sa ? (~a_op + WIDTH'(1)) : a_op;
  assign mag_b = sb ? (~b_op + WIDTH'(1)) : b_op;

  vedic_umult #(.N(WIDTH)) u_core (
    .a(mag_a),
    .b(mag_b),
    .p(mag)
  );

  assign prod = (sa ^ sb) ? (~mag + (2*WIDTH)'(1)) : mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= prod;
  end

endmodule

// File: tb/tb_signed_vedic_mult.sv
// tb/tb_signed_vedic_mult.sv - randomized and directed bench for signed_vedic_mult at WIDTH 32, 8, 4, 2
`timescale 1ns/1ps
module tb_signed_vedic_mult;

`ifdef SIGNED_VEDIC_MULT_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] o32;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] o8;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  o4;
  logic [1:0]  a2 = '0, b2 = '0;
  logic [3:0]  o2;

  int n_vec = 0;
  int n_err = 0;
  bit chk = 1'b0;

  logic [63:0] p32 [LAT];
  logic [15:0] p8  [LAT];
  logic [7:0]  p4  [LAT];
  logic [3:0]  p2  [LAT];

  always #5 clk = ~clk;

  signed_vedic_mult #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .out(o32));
  signed_vedic_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .a(a8),  .b(b8),  .out(o8));
  signed_vedic_mult #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .a(a4),  .b(b4),  .out(o4));
  signed_vedic_mult #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .a(a2),  .b(b2),  .out(o2));

  // Reference: a queue of LAT signed products, flushed to zero by reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        p32[i] <= '0; p8[i] <= '0; p4[i] <= '0; p2[i] <= '0;
      end
    end else begin
      p32[0] <= 64'(longint'($signed(a32)) * longint'($signed(b32)));
      p8[0]  <= 16'(int'($signed(a8)) * int'($signed(b8)));
      p4[0]  <= 8'(int'($signed(a4)) * int'($signed(b4)));
      p2[0]  <= 4'(int'($signed(a2)) * int'($signed(b2)));
      for (int i = 1; i < LAT; i++) begin
        p32[i] <= p32[i-1]; p8[i] <= p8[i-1]; p4[i] <= p4[i-1]; p2[i] <= p2[i-1];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("out32", o32, p32[LAT-1]);
      check("out8",  o8,  p8[LAT-1]);
      check("out4",  o4,  p4[LAT-1]);
      check("out2",  o2,  p2[LAT-1]);
    end
  end

  task automatic apply32(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic [63:0] exp);
    @(negedge clk);
    a32 = va; b32 = vb;
    repeat (LAT) @(posedge clk);
    #1 check(name, o32, exp);
  endtask

  task automatic apply4(input string name, input logic [3:0] va, input logic [3:0] vb,
                        input logic [7:0] exp);
    @(negedge clk);
    a4 = va; b4 = vb;
    repeat (LAT) @(posedge clk);
    #1 check(name, {56'h0, o4}, {56'h0, exp});
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic randomize_inputs();
    a32 = pick32(); b32 = pick32();
    a8 = 8'($urandom); b8 = 8'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom);
    a2 = 2'($urandom); b2 = 2'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    randomize_inputs();
    #1 rst_n = 1'b0;
    #1;
    check("reset32", o32, 64'h0);
    check("reset8",  {48'h0, o8}, 64'h0);
    chk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    apply32("q_pp", 32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006);
    apply32("q_np", 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
    apply32("q_pn", 32'h0000_0002, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA);
    apply32("q_nn", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006);
    apply32("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    apply32("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    apply32("zero_neg", 32'h0000_0000, 32'hFFFF_FFFF, 64'h0);
    apply4("w4_min_min", 4'h8, 4'h8, 8'h40);
    apply4("w4_max_min", 4'h7, 4'h8, 8'hC8);

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      randomize_inputs();
    end

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v = i[7:0];
      a4 = v[7:4]; b4 = v[3:0];
      a2 = v[3:2]; b2 = v[1:0];
      a8 = 8'($urandom); b8 = 8'($urandom);
      a32 = $urandom; b32 = $urandom;
    end

    @(negedge clk);
    a32 = 32'h0000_0005; b32 = 32'hFFFF_FFF9;
    repeat (LAT) @(posedge clk);
    #1 check("pre_rst", o32, 64'hFFFF_FFFF_FFFF_FFDD);
    #1 rst_n = 1'b0;
    #1 check("async_rst", o32, 64'h0);
    repeat (2) @(negedge clk);
    a32 = 32'h0000_0011; b32 = 32'h0000_0003;
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1 check("post_rst", o32, 64'h33);

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      randomize_inputs();
    end
    @(negedge clk);
    chk = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
